// File: rtl/bus6502_bridge.sv
// 6502 CPU bus to SDRAM bridge.
// Until the SDRAM image is loaded, reads are answered from a boot stub: a JMP opcode plus
// NMI/RESET/IRQ vectors, with NOP fill everywhere else. After the switch read, bytes come from
// SDRAM through a single-entry write-through cache. A response timeout returns 8'hFF and sets a
// sticky error flag, so a stalled controller can never hang the CPU bus.
module bus6502_bridge #(
    parameter int unsigned              ADDR_WIDTH  = 15,
    parameter logic [22-ADDR_WIDTH:0]   RAM_PAGE    = (23 - ADDR_WIDTH)'(1),
    parameter logic [ADDR_WIDTH-1:0]    STUB_ADDR   = ADDR_WIDTH'('h7FF9),
    parameter logic [15:0]              BOOT_TARGET = 16'hC000,
    parameter logic [ADDR_WIDTH-1:0]    SWITCH_ADDR = ADDR_WIDTH'('h7FFC),
    parameter int unsigned              TIMEOUT     = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] c6502_addr,
    input  logic                  c6502_rw,
    input  logic                  c6502_cs,
    input  logic [7:0]            c6502_data_in,
    output logic [7:0]            c6502_data,
    output logic                  c6502_data_oe,
    output logic [22:0]           ram_addr,
    output logic                  ram_rw,
    output logic [7:0]            ram_wdata,
    output logic                  in_valid,
    input  logic                  busy,
    input  logic [7:0]            data_out,
    input  logic                  out_valid,
    input  logic                  init_sdram_data,
    output logic                  err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Fixed 6502 vector locations, truncated to the bridge's address width.
    localparam logic [ADDR_WIDTH-1:0] VEC_NMI_LO = ADDR_WIDTH'('h7FFA);
    localparam logic [ADDR_WIDTH-1:0] VEC_NMI_HI = ADDR_WIDTH'('h7FFB);
    localparam logic [ADDR_WIDTH-1:0] VEC_RST_LO = ADDR_WIDTH'('h7FFC);
    localparam logic [ADDR_WIDTH-1:0] VEC_RST_HI = ADDR_WIDTH'('h7FFD);
    localparam logic [ADDR_WIDTH-1:0] VEC_IRQ_LO = ADDR_WIDTH'('h7FFE);
    localparam logic [ADDR_WIDTH-1:0] VEC_IRQ_HI = ADDR_WIDTH'('h7FFF);
    localparam logic [ADDR_WIDTH-1:0] STUB_LO    = STUB_ADDR + ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] STUB_HI    = STUB_ADDR + ADDR_WIDTH'(2);

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StIssue,
        StWait,
        StRelease
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    rw_q, rw_d;
    logic [7:0]              wdata_q, wdata_d;
    logic [7:0]              data_q, data_d;
    logic                    oe_q, oe_d;
    logic [22:0]             ram_addr_q, ram_addr_d;
    logic                    ram_rw_q, ram_rw_d;
    logic [7:0]              ram_wdata_q, ram_wdata_d;
    logic                    in_valid_q, in_valid_d;
    logic                    err_q, err_d;
    logic                    sdram_ok_q, sdram_ok_d;
    logic                    cache_valid_q, cache_valid_d;
    logic [ADDR_WIDTH-1:0]   cache_tag_q, cache_tag_d;
    logic [7:0]              cache_data_q, cache_data_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [7:0]              stub_byte;
    logic                    cache_hit;

    assign cache_hit = cache_valid_q && (cache_tag_q == addr_q);

    // Boot stub contents for the latched address; the switch address only reaches the
    // last branch when the SDRAM image is not yet loaded.
    always_comb begin
        stub_byte = 8'hEA;
        if (addr_q == STUB_ADDR) begin
            stub_byte = 8'h4C;
        end else if (addr_q == STUB_LO || addr_q == VEC_NMI_LO || addr_q == VEC_RST_LO ||
                     addr_q == VEC_IRQ_LO) begin
            stub_byte = BOOT_TARGET[7:0];
        end else if (addr_q == STUB_HI || addr_q == VEC_NMI_HI || addr_q == VEC_RST_HI ||
                     addr_q == VEC_IRQ_HI) begin
            stub_byte = BOOT_TARGET[15:8];
        end else if (addr_q == SWITCH_ADDR) begin
            stub_byte = BOOT_TARGET[7:0];
        end
    end

    // Transaction FSM: next state and next values of every registered output.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rw_d          = rw_q;
        wdata_d       = wdata_q;
        data_d        = data_q;
        oe_d          = oe_q;
        ram_addr_d    = ram_addr_q;
        ram_rw_d      = ram_rw_q;
        ram_wdata_d   = ram_wdata_q;
        in_valid_d    = 1'b0;
        err_d         = err_q;
        sdram_ok_d    = sdram_ok_q;
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_data_d  = cache_data_q;
        cnt_d         = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (!c6502_cs) begin
                    addr_d  = c6502_addr;
                    rw_d    = c6502_rw;
                    wdata_d = c6502_data_in;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (!sdram_ok_q) begin
                    if (!rw_q) begin
                        // Writes before the image is loaded have nowhere to go.
                        state_d = StRelease;
                    end else if (addr_q == SWITCH_ADDR && init_sdram_data) begin
                        sdram_ok_d = 1'b1;
                        state_d    = StIssue;
                    end else begin
                        data_d  = stub_byte;
                        state_d = StRelease;
                    end
                end else if (rw_q && cache_hit) begin
                    data_d  = cache_data_q;
                    state_d = StRelease;
                end else begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (!busy) begin
                    in_valid_d  = 1'b1;
                    ram_addr_d  = {RAM_PAGE, addr_q};
                    ram_rw_d    = ~rw_q;
                    ram_wdata_d = wdata_q;
                    if (rw_q) begin
                        cnt_d   = '0;
                        state_d = StWait;
                    end else begin
                        // Posted write; keep the cached copy coherent.
                        if (cache_hit) begin
                            cache_data_d = wdata_q;
                        end
                        state_d = StRelease;
                    end
                end
            end
            StWait: begin
                // A response in the final counted cycle still beats the timeout.
                if (out_valid) begin
                    data_d        = data_out;
                    cache_tag_d   = addr_q;
                    cache_data_d  = data_out;
                    cache_valid_d = 1'b1;
                    state_d       = StRelease;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = 8'hFF;
                    err_d   = 1'b1;
                    state_d = StRelease;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRelease: begin
                if (c6502_cs) begin
                    oe_d    = 1'b0;
                    state_d = StIdle;
                end else begin
                    oe_d = rw_q;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            rw_q          <= 1'b1;
            wdata_q       <= '0;
            data_q        <= '0;
            oe_q          <= 1'b0;
            ram_addr_q    <= '0;
            ram_rw_q      <= 1'b0;
            ram_wdata_q   <= '0;
            in_valid_q    <= 1'b0;
            err_q         <= 1'b0;
            sdram_ok_q    <= 1'b0;
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_data_q  <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rw_q          <= rw_d;
            wdata_q       <= wdata_d;
            data_q        <= data_d;
            oe_q          <= oe_d;
            ram_addr_q    <= ram_addr_d;
            ram_rw_q      <= ram_rw_d;
            ram_wdata_q   <= ram_wdata_d;
            in_valid_q    <= in_valid_d;
            err_q         <= err_d;
            sdram_ok_q    <= sdram_ok_d;
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_data_q  <= cache_data_d;
            cnt_q         <= cnt_d;
        end
    end

    assign c6502_data    = data_q;
    assign c6502_data_oe = oe_q;
    assign ram_addr      = ram_addr_q;
    assign ram_rw        = ram_rw_q;
    assign ram_wdata     = ram_wdata_q;
    assign in_valid      = in_valid_q;
    assign err           = err_q;

endmodule

// File: tb/tb_bus6502_bridge.sv
// Directed bench for bus6502_bridge: boot stub, mode switch, cache, busy stall, timeout,
// and reset during an outstanding read. A small SDRAM responder answers read requests.
module tb_bus6502_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] c6502_addr;
    logic        c6502_rw;
    logic        c6502_cs;
    logic [7:0]  c6502_data_in;
    logic [7:0]  c6502_data;
    logic        c6502_data_oe;
    logic [22:0] ram_addr;
    logic        ram_rw;
    logic [7:0]  ram_wdata;
    logic        in_valid;
    logic        busy;
    logic [7:0]  data_out;
    logic        out_valid = 1'b0;
    logic        init_sdram_data;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Responder controls and request log.
    logic        resp_en    = 1'b1;
    int          resp_delay = 0;
    logic [7:0]  resp_data  = 8'h00;
    logic        pend       = 1'b0;
    int          dly        = 0;
    int          inval_cnt  = 0;
    logic [22:0] last_addr  = '0;
    logic        last_rw    = 1'b0;
    logic [7:0]  last_wdata = '0;

    bus6502_bridge #(
        .TIMEOUT(8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .c6502_addr     (c6502_addr),
        .c6502_rw       (c6502_rw),
        .c6502_cs       (c6502_cs),
        .c6502_data_in  (c6502_data_in),
        .c6502_data     (c6502_data),
        .c6502_data_oe  (c6502_data_oe),
        .ram_addr       (ram_addr),
        .ram_rw         (ram_rw),
        .ram_wdata      (ram_wdata),
        .in_valid       (in_valid),
        .busy           (busy),
        .data_out       (data_out),
        .out_valid      (out_valid),
        .init_sdram_data(init_sdram_data),
        .err            (err)
    );

    always #5 clk = ~clk;

    // SDRAM responder: a read request seen at edge N is answered so that the bridge
    // samples out_valid at edge N+1+resp_delay. Pending replies survive reset on purpose.
    always @(posedge clk) begin
        out_valid <= 1'b0;
        if (pend) begin
            if (dly == 0) begin
                out_valid <= 1'b1;
                data_out  <= resp_data;
                pend      <= 1'b0;
            end else begin
                dly <= dly - 1;
            end
        end
        if (in_valid) begin
            inval_cnt  <= inval_cnt + 1;
            last_addr  <= ram_addr;
            last_rw    <= ram_rw;
            last_wdata <= ram_wdata;
            if (!ram_rw && resp_en) begin
                if (resp_delay == 0) begin
                    out_valid <= 1'b1;
                    data_out  <= resp_data;
                end else begin
                    pend <= 1'b1;
                    dly  <= resp_delay - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Read cycle: returns the byte on the bus and the cycles from cs low to oe high.
    task automatic cpu_read(input logic [14:0] a, output logic [7:0] d, output int cyc);
        int guard;
        @(negedge clk);
        c6502_addr = a;
        c6502_rw   = 1'b1;
        c6502_cs   = 1'b0;
        cyc = 0;
        while (c6502_data_oe !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        d = c6502_data;
        c6502_cs = 1'b1;
        guard = 0;
        while (c6502_data_oe !== 1'b0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic cpu_write(input logic [14:0] a, input logic [7:0] wd);
        @(negedge clk);
        c6502_addr    = a;
        c6502_rw      = 1'b0;
        c6502_data_in = wd;
        c6502_cs      = 1'b0;
        repeat (6) @(negedge clk);
        c6502_cs = 1'b1;
        c6502_rw = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         cyc;
        int         base;
        logic       seen;

        rst             = 1'b1;
        c6502_addr      = '0;
        c6502_rw        = 1'b1;
        c6502_cs        = 1'b1;
        c6502_data_in   = '0;
        busy            = 1'b0;
        init_sdram_data = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst_data", c6502_data, 8'h00);
        check("rst_oe", c6502_data_oe, 1'b0);
        check("rst_in_valid", in_valid, 1'b0);
        check("rst_ram_rw", ram_rw, 1'b0);
        check("rst_ram_wdata", ram_wdata, 8'h00);
        check("rst_ram_addr", ram_addr, 23'h0);
        check("rst_err", err, 1'b0);

        // Boot stub.
        cpu_read(15'h7FF9, d, cyc);
        check("boot_jmp", d, 8'h4C);
        check("boot_jmp_cyc", cyc, 3);
        cpu_read(15'h7FFA, d, cyc);
        check("boot_7ffa", d, 8'h00);
        cpu_read(15'h7FFB, d, cyc);
        check("boot_7ffb", d, 8'hC0);
        cpu_read(15'h1234, d, cyc);
        check("boot_nop", d, 8'hEA);
        cpu_read(15'h7FFC, d, cyc);
        check("boot_switch_noinit", d, 8'h00);
        cpu_read(15'h7FFF, d, cyc);
        check("boot_7fff", d, 8'hC0);
        cpu_write(15'h1234, 8'h55);
        check("boot_no_in_valid", inval_cnt, 0);

        // Mode switch.
        init_sdram_data = 1'b1;
        resp_data = 8'h5A;
        cpu_read(15'h7FFC, d, cyc);
        check("sw_data", d, 8'h5A);
        check("sw_cyc", cyc, 6);
        check("sw_in_valid", inval_cnt, 1);
        check("sw_ram_addr", last_addr, 23'h00FFFC);
        check("sw_ram_rw", last_rw, 1'b0);

        // Cache: miss, hit, write-through, hit.
        resp_data = 8'h33;
        cpu_read(15'h0100, d, cyc);
        check("c_miss_data", d, 8'h33);
        check("c_miss_in_valid", inval_cnt, 2);
        resp_data = 8'h99;
        cpu_read(15'h0100, d, cyc);
        check("c_hit_data", d, 8'h33);
        check("c_hit_cyc", cyc, 3);
        check("c_hit_in_valid", inval_cnt, 2);
        cpu_write(15'h0100, 8'h77);
        check("c_wr_in_valid", inval_cnt, 3);
        check("c_wr_ram_rw", last_rw, 1'b1);
        check("c_wr_ram_wdata", last_wdata, 8'h77);
        check("c_wr_ram_addr", last_addr, 23'h008100);
        cpu_read(15'h0100, d, cyc);
        check("c_rehit_data", d, 8'h77);
        check("c_rehit_in_valid", inval_cnt, 3);

        // Busy stall.
        busy = 1'b1;
        resp_data = 8'h44;
        @(negedge clk);
        c6502_addr = 15'h0200;
        c6502_rw   = 1'b1;
        c6502_cs   = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (in_valid) seen = 1'b1;
        end
        check("busy_no_in_valid", seen, 1'b0);
        busy = 1'b0;
        @(negedge clk);
        check("busy_release_in_valid", in_valid, 1'b1);
        cyc = 0;
        while (c6502_data_oe !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("busy_data", c6502_data, 8'h44);
        c6502_cs = 1'b1;
        repeat (2) @(negedge clk);
        check("busy_in_valid_cnt", inval_cnt, 4);

        // Response in the last counted WAIT cycle wins.
        resp_delay = 6;
        resp_data  = 8'h66;
        cpu_read(15'h0300, d, cyc);
        check("to_edge_data", d, 8'h66);
        check("to_edge_cyc", cyc, 12);
        check("to_edge_err", err, 1'b0);

        // Response one cycle too late: timeout.
        resp_delay = 7;
        resp_data  = 8'h67;
        cpu_read(15'h0301, d, cyc);
        check("to_late_data", d, 8'hFF);
        check("to_late_cyc", cyc, 12);
        check("to_late_err", err, 1'b1);

        // No response at all; err stays set and the cache keeps 0300.
        resp_en = 1'b0;
        cpu_read(15'h0302, d, cyc);
        check("to_none_data", d, 8'hFF);
        check("to_none_err", err, 1'b1);
        resp_en    = 1'b1;
        resp_delay = 0;
        resp_data  = 8'h11;
        cpu_read(15'h0300, d, cyc);
        check("to_cache_kept", d, 8'h66);
        check("to_cache_in_valid", inval_cnt, 7);
        check("to_err_sticky", err, 1'b1);

        // Reset while waiting; the late reply must be ignored.
        init_sdram_data = 1'b0;
        resp_delay = 5;
        resp_data  = 8'h22;
        @(negedge clk);
        c6502_addr = 15'h0400;
        c6502_rw   = 1'b1;
        c6502_cs   = 1'b0;
        repeat (5) @(negedge clk);
        check("rw_req_issued", inval_cnt, 8);
        rst      = 1'b1;
        c6502_cs = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        base = inval_cnt;
        repeat (6) @(negedge clk);
        check("rw_oe", c6502_data_oe, 1'b0);
        check("rw_data", c6502_data, 8'h00);
        check("rw_err", err, 1'b0);
        check("rw_no_in_valid", inval_cnt, base);
        cpu_read(15'h7FFC, d, cyc);
        check("rw_boot_again", d, 8'h00);
        check("rw_boot_cyc", cyc, 3);
        check("rw_boot_no_in_valid", inval_cnt, base);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
